tmds_multimode_encoder: RTL
===========================

// Module: tmds_multimode_encoder
// PURPOSE
//  Per-channel HDMI TMDS encoder and parametrised successor to the video-only encoder.
//  Encodes DVI 1.0 video pixels, control periods, TERC4 data-island symbols, and video or data-island guard bands.
//  Latency is configurable and the running disparity is exposed for checking.
//  Instantiated once per lane (CHANNEL 0=blue, 1=green, 2=red), between the video/packet scheduler and the OSER10 serialisers.
// PARAMETERS
//  CHANNEL  0  lane index 0..2; selects the guard-band code.
//  LATENCY  4  i_* sample edge to o_tmds update, in cycles; legal 3..8; stages beyond 3 are pure retiming.
// PORTS
//  i_hdmi_clk   in   1   pixel clock; the block's single clock.
//  i_reset_n    in   1   asynchronous active-low reset.
//  i_mode       in   3   0 control, 1 video, 2 TERC4, 3 video guard, 4 data-island guard, 5-7 reserved.
//  i_data       in   8   video pixel component (used in mode 1).
//  i_ctrl       in   2   {c1,c0} control bits (used in mode 0).
//  i_terc4      in   4   TERC4 nibble (mode 2; also mode 4 when CHANNEL=0).
//  o_tmds       out  10  encoded symbol; bit 0 is serialised first.
//  o_valid      out  1   high once the pipeline holds post-reset data.
//  o_disparity  out  6   signed running DVI cnt after the current o_tmds symbol.
// BEHAVIOUR
//  Reset (asynchronous assert, synchronous release)
//   - All pipeline registers clear to mode 0 with ctrl 00.
//   - o_tmds=10'h354, o_valid=0, o_disparity=0.
//   - o_valid rises on the LATENCY-th rising edge after i_reset_n deasserts, then stays high.
//   - Asserting reset mid-stream forces the reset values immediately and discards in-flight symbols.
//  Pipeline
//   - Fully pipelined: one symbol per clock, no stalls, and i_mode may change every cycle.
//   - All per-symbol fields travel with the mode through the pipeline.
//   - Only the final stage holds state: the disparity register.
//  Mode 1 (video), per DVI 1.0 section 3.2.2
//   - q_m is the XNOR chain if N1(d)>4, or N1(d)==4 with d[0]==0; otherwise it is the XOR chain. q_m[8] = XOR-chain select.
//   - If cnt==0 or N1(q_m[7:0])==N0:
//     - out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}.
//     - cnt += q_m8 ? N1-N0 : N0-N1.
//   - Else if (cnt>0 && N1>N0) || (cnt<0 && N0>N1):
//     - out = {1, q_m8, ~q_m[7:0]}.
//     - cnt += 2*q_m8 + N0-N1.
//   - Else:
//     - out = {0, q_m8, q_m[7:0]}.
//     - cnt += N1-N0 - 2*~q_m8.
//   - cnt is 6-bit two's complement and never leaves -16..+16, so no saturation is required.
//  Mode 0 (control)
//   - ctrl 00 -> 10'h354, 01 -> 10'h0AB, 10 -> 10'h154, 11 -> 10'h2AB.
//  Mode 2 (TERC4), nibble 0..F ->
//   - 29C 263 2E4 2E2 171 11E 18E 13C
//   - 2CC 139 19C 2C6 28E 271 163 2C3
//  Mode 3 (video guard)
//   - CHANNEL 0 and 2 -> 10'h2CC; CHANNEL 1 -> 10'h133.
//  Mode 4 (data-island guard)
//   - CHANNEL 1 and 2 -> 10'h133.
//   - CHANNEL 0 -> TERC4(i_terc4); the upstream scheduler supplies {1,1,vsync,hsync}.
//  Modes 5-7
//   - Treated as mode 0 with ctrl 00 -> 10'h354.
//  Disparity
//   - Every non-video symbol clears cnt to 0 on the same edge it is output.
//   - A video symbol following any non-video symbol therefore starts from cnt=0.
//  Out-of-range parameters
//   - CHANNEL>2 or LATENCY outside 3..8 is a elaboration-time $error.
// TESTING
//  T1 Reset release with mode 0, ctrl 00 held
//   -> o_valid=0 for LATENCY-1 edges and high from edge LATENCY; o_tmds=10'h354 throughout; o_disparity=0.
//  T2 From mode 0, three video pixels 0x00
//   -> o_tmds 10'h100, 10'h3FF, 10'h100; o_disparity -8, +2, -6; one symbol per cycle at LATENCY.
//  T3 Mode 2, nibbles 0,8,F back-to-back
//   -> 10'h29C, 10'h2CC, 10'h2C3; o_disparity stays 0.
//  T4 Guard bands
//   -> CHANNEL=0 mode 3 gives 10'h2CC; CHANNEL=1 mode 3 and mode 4 give 10'h133.
//   -> CHANNEL=0 mode 4 with i_terc4=4'hC gives 10'h28E.
//  T5 Pull i_reset_n low asynchronously (between edges) mid video stream
//   -> 10'h354, o_valid=0 and o_disparity=0 immediately.
//   -> After release, the first LATENCY outputs are 10'h354 regardless of inputs.
//  T6 Mode 7 between video pixels, then video 0x00
//   -> 10'h354; the next pixel encodes from cnt=0 as 10'h100 with disparity -8.
//   -> Repeat T2/T6 with LATENCY=3 and LATENCY=8: same symbols, shifted timing.

Source files
------------

// File: rtl/tmds_multimode_encoder_if.sv
// ----------------------------------------------------------------------------
// tmds_multimode_encoder_if
// Symbol bus between the video/packet scheduler and one TMDS lane encoder.
//   i_mode      [2:0]  0 control, 1 video, 2 TERC4, 3 video guard,
//                      4 data-island guard, 5-7 reserved (encoded as control 00)
//   i_data      [7:0]  video pixel component
//   i_ctrl      [1:0]  {c1,c0}
//   i_terc4     [3:0]  TERC4 nibble
//   o_tmds      [9:0]  encoded symbol, bit 0 serialised first
//   o_valid            pipeline holds post-reset data
//   o_disparity [5:0]  signed running disparity after o_tmds
// master: scheduler side.  slave: encoder side.
// ----------------------------------------------------------------------------
interface tmds_multimode_encoder_if;
  logic [2:0] i_mode;
  logic [7:0] i_data;
  logic [1:0] i_ctrl;
  logic [3:0] i_terc4;
  logic [9:0] o_tmds;
  logic       o_valid;
  logic [5:0] o_disparity;

  modport master (
    output i_mode, i_data, i_ctrl, i_terc4,
    input  o_tmds, o_valid, o_disparity
  );

  modport slave (
    input  i_mode, i_data, i_ctrl, i_terc4,
    output o_tmds, o_valid, o_disparity
  );
endinterface

// File: rtl/tmds_multimode_encoder.sv
// ----------------------------------------------------------------------------
// tmds_multimode_encoder
// Per-lane HDMI TMDS encoder: DVI video, control periods, TERC4 data-island
// symbols and guard bands, with configurable pipeline depth.
// Parameters:
//   CHANNEL  lane index 0..2 (0 blue, 1 green, 2 red); selects guard codes
//   LATENCY  register stages from input sample to o_tmds, 3..8
// Ports:
//   i_hdmi_clk  pixel clock
//   i_reset_n   asynchronous active-low reset
//   io_bus      slave side of tmds_multimode_encoder_if
// Pipeline: stage 1 registers the inputs, stage 2 holds q_m and the
// precomputed non-video code, stages 3..LATENCY-1 are retiming, and the last
// stage does the disparity-dependent video encode and holds the disparity.
// ----------------------------------------------------------------------------
module tmds_multimode_encoder #(
  parameter int CHANNEL = 0,
  parameter int LATENCY = 4
) (
  input  logic                     i_hdmi_clk,
  input  logic                     i_reset_n,
  tmds_multimode_encoder_if.slave  io_bus
);

  if (CHANNEL < 0 || CHANNEL > 2) begin : g_bad_channel
    $error("tmds_multimode_encoder: CHANNEL must be 0..2");
  end
  if (LATENCY < 3 || LATENCY > 8) begin : g_bad_latency
    $error("tmds_multimode_encoder: LATENCY must be 3..8");
  end

  localparam logic [2:0] MODE_CTRL   = 3'd0;
  localparam logic [2:0] MODE_VIDEO  = 3'd1;
  localparam logic [2:0] MODE_TERC4  = 3'd2;
  localparam logic [2:0] MODE_VGUARD = 3'd3;
  localparam logic [2:0] MODE_DGUARD = 3'd4;

  localparam logic [9:0] SYM_CTRL00 = 10'h354;
  localparam logic [9:0] SYM_GUARD_A = 10'h2CC;
  localparam logic [9:0] SYM_GUARD_B = 10'h133;

  typedef struct packed {
    logic       vld;
    logic       is_video;
    logic [8:0] qm;
    logic [3:0] n1;     // ones in qm[7:0]
    logic [9:0] code;   // finished symbol for non-video modes
  } stage_t;

  localparam stage_t STAGE_RST = '{vld: 1'b0, is_video: 1'b0, qm: 9'd0,
                                   n1: 4'd0, code: SYM_CTRL00};

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Transition-minimising stage; q[8]=1 marks the XOR chain.
  function automatic logic [8:0] qm_encode(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] terc4_code(input logic [3:0] t);
    logic [9:0] c;
    case (t)
      4'h0: c = 10'h29C;  4'h1: c = 10'h263;  4'h2: c = 10'h2E4;  4'h3: c = 10'h2E2;
      4'h4: c = 10'h171;  4'h5: c = 10'h11E;  4'h6: c = 10'h18E;  4'h7: c = 10'h13C;
      4'h8: c = 10'h2CC;  4'h9: c = 10'h139;  4'hA: c = 10'h19C;  4'hB: c = 10'h2C6;
      4'hC: c = 10'h28E;  4'hD: c = 10'h271;  4'hE: c = 10'h163;  default: c = 10'h2C3;
    endcase
    return c;
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'h354;
      2'b01:   s = 10'h0AB;
      2'b10:   s = 10'h154;
      default: s = 10'h2AB;
    endcase
    return s;
  endfunction

  // ---------------- stage 1: input registers ----------------
  logic       r_s1_vld;
  logic [2:0] r_s1_mode;
  logic [7:0] r_s1_data;
  logic [1:0] r_s1_ctrl;
  logic [3:0] r_s1_terc4;

  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_mode  <= MODE_CTRL;
      r_s1_data  <= 8'd0;
      r_s1_ctrl  <= 2'b00;
      r_s1_terc4 <= 4'd0;
    end else begin
      r_s1_vld   <= 1'b1;
      r_s1_mode  <= io_bus.i_mode;
      r_s1_data  <= io_bus.i_data;
      r_s1_ctrl  <= io_bus.i_ctrl;
      r_s1_terc4 <= io_bus.i_terc4;
    end
  end

  // ---------------- stage 2: q_m and non-video lookup ----------------
  stage_t     w_s2;
  logic [8:0] w_qm;

  assign w_qm = qm_encode(r_s1_data);

  always_comb begin
    w_s2          = STAGE_RST;
    w_s2.vld      = r_s1_vld;
    w_s2.is_video = (r_s1_mode == MODE_VIDEO);
    w_s2.qm       = w_qm;
    w_s2.n1       = popcount8(w_qm[7:0]);
    case (r_s1_mode)
      MODE_CTRL:   w_s2.code = ctrl_code(r_s1_ctrl);
      MODE_TERC4:  w_s2.code = terc4_code(r_s1_terc4);
      MODE_VGUARD: w_s2.code = (CHANNEL == 1) ? SYM_GUARD_B : SYM_GUARD_A;
      // Lane 0 carries {1,1,vsync,hsync} as TERC4 during the island guard.
      MODE_DGUARD: w_s2.code = (CHANNEL == 0) ? terc4_code(r_s1_terc4) : SYM_GUARD_B;
      default:     w_s2.code = SYM_CTRL00;
    endcase
  end

  stage_t r_pipe [2:LATENCY-1];

  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 2; k <= LATENCY - 1; k++) r_pipe[k] <= STAGE_RST;
    end else begin
      r_pipe[2] <= w_s2;
      for (int k = 3; k <= LATENCY - 1; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  // ---------------- final stage: disparity-aware video encode ----------------
  stage_t            w_last;
  logic              w_qm8;
  logic signed [5:0] w_diff;     // N1 - N0 of qm[7:0]
  logic [9:0]        w_vid_sym;
  logic signed [5:0] w_cnt_nxt;
  logic [9:0]        r_tmds;
  logic              r_vld;
  logic signed [5:0] r_cnt;

  assign w_last = r_pipe[LATENCY-1];
  assign w_qm8  = w_last.qm[8];
  assign w_diff = $signed({1'b0, w_last.n1, 1'b0}) - 6'sd8;

  always_comb begin
    w_vid_sym = {1'b0, w_qm8, w_last.qm[7:0]};
    w_cnt_nxt = r_cnt;
    if (r_cnt == 6'sd0 || w_last.n1 == 4'd4) begin
      w_vid_sym = {~w_qm8, w_qm8, w_qm8 ? w_last.qm[7:0] : ~w_last.qm[7:0]};
      w_cnt_nxt = w_qm8 ? (r_cnt + w_diff) : (r_cnt - w_diff);
    end else if ((r_cnt > 6'sd0 && w_last.n1 > 4'd4) ||
                 (r_cnt < 6'sd0 && w_last.n1 < 4'd4)) begin
      w_vid_sym = {1'b1, w_qm8, ~w_last.qm[7:0]};
      w_cnt_nxt = r_cnt + $signed({4'b0000, w_qm8, 1'b0}) - w_diff;
    end else begin
      w_vid_sym = {1'b0, w_qm8, w_last.qm[7:0]};
      w_cnt_nxt = r_cnt + w_diff - (w_qm8 ? 6'sd0 : 6'sd2);
    end
  end

  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tmds <= SYM_CTRL00;
      r_vld  <= 1'b0;
      r_cnt  <= 6'sd0;
    end else begin
      r_vld <= w_last.vld;
      if (w_last.is_video) begin
        r_tmds <= w_vid_sym;
        r_cnt  <= w_cnt_nxt;
      end else begin
        // Any non-video symbol restarts the DVI running disparity.
        r_tmds <= w_last.code;
        r_cnt  <= 6'sd0;
      end
    end
  end

  assign io_bus.o_tmds      = r_tmds;
  assign io_bus.o_valid     = r_vld;
  assign io_bus.o_disparity = r_cnt;

endmodule
